// File: rtl/core_seq_if.sv
// Sequencer-side bundle: host start/done handshake, core instruction word and
// output-pixel strobes.
interface core_seq_if;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        core_reset;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, ofifo_valid,
    output inst, core_reset, out_valid, out_idx, busy, done, err
  );

  modport slave (
    output start, ofifo_valid,
    input  inst, core_reset, out_valid, out_idx, busy, done, err
  );
endinterface

// File: rtl/core_seq.sv
// Convolution sequencer for core: per-kij weight/activation load, execute and
// OFIFO drain to pmem, then per-pixel psum accumulation. Optional drain
// watchdog enabled by defining CORE_SEQ_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for start
// W_L0         | xmem weight rows -> L0
// LOAD         | L0 weights -> PE array
// GAP          | settle between weight load and activations
// A_L0         | xmem activations -> L0
// EXEC         | stream activations through the array
// DRAIN_WAIT   | poll OFIFO until valid
// DRAIN        | OFIFO -> pmem at kij*len_nij + t
// ACC_CLR      | clear core accumulators for the next pixel
// ACC_RD       | read the len_kij psums of one pixel, accumulate
// ACC_END      | close accumulation
// OUT          | sfp_out holds pixel o
// DONE         | completion pulse
module core_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int len_kij = 9,
  parameter int in_w    = 6,
  parameter int out_w   = 4,
  parameter int ksz     = 3,
  parameter int gap_cyc = 11,
  parameter logic [10:0] w_base = 11'h400
) (
  input  logic       clk,
  input  logic       reset,
  core_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_LOAD, S_GAP, S_A_L0, S_EXEC, S_DRAIN_WAIT, S_DRAIN,
    S_ACC_CLR, S_ACC_RD, S_ACC_END, S_OUT, S_DONE
  } state_t;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  localparam int B_ACC = 33, B_CEN_P = 32, B_WEN_P = 31, B_CEN_X = 19;
  localparam int B_OFIFO_RD = 6, B_L0_RD = 3, B_L0_WR = 2, B_EXEC = 1, B_LOAD = 0;

  localparam logic [7:0] COL8      = 8'(col);
  localparam logic [7:0] NIJ8      = 8'(len_nij);
  localparam logic [7:0] KIJ8      = 8'(len_kij);
  localparam logic [7:0] T_LOAD_E  = 8'(col - 1);
  localparam logic [7:0] T_GAP_E   = 8'(gap_cyc - 1);
  localparam logic [7:0] T_EXEC_E  = 8'(len_nij + row + col - 1);
  localparam logic [7:0] T_DRAIN_E = 8'(len_nij - 1);
  localparam logic [3:0] KIJ_E     = 4'(len_kij - 1);
  localparam logic [3:0] O_E       = 4'(out_w * out_w - 1);
  localparam logic [1:0] C_E       = 2'(out_w - 1);
  localparam logic [1:0] KJ_E      = 2'(ksz - 1);
  localparam logic [10:0] COL11    = 11'(col);
  localparam logic [10:0] NIJ11    = 11'(len_nij);
  localparam logic [10:0] IN_W11   = 11'(in_w);

  state_t      state, state_n;
  logic [7:0]  t, t_n;
  logic [3:0]  kij, kij_n;
  logic [3:0]  o, o_n;
  logic [1:0]  r, r_n, c, c_n;
  logic [1:0]  ki, ki_n, kj, kj_n;

  logic [33:0] inst_q, inst_n;
  logic        core_reset_q, core_reset_n;
  logic        out_valid_q, out_valid_n;
  logic [3:0]  out_idx_q, out_idx_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic [10:0] acc_addr;

`ifdef CORE_SEQ_TIMEOUT_EN
  localparam int tmo_cyc = 64;
  localparam logic [7:0] T_TMO_E = 8'(tmo_cyc - 1);
  logic tmo_hit;
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      t            <= '0;
      kij          <= '0;
      o            <= '0;
      r            <= '0;
      c            <= '0;
      ki           <= '0;
      kj           <= '0;
      inst_q       <= INST_IDLE;
      core_reset_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      t            <= t_n;
      kij          <= kij_n;
      o            <= o_n;
      r            <= r_n;
      c            <= c_n;
      ki           <= ki_n;
      kj           <= kj_n;
      inst_q       <= inst_n;
      core_reset_q <= core_reset_n;
      out_valid_q  <= out_valid_n;
      out_idx_q    <= out_idx_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    kij_n   = kij;
    o_n     = o;
    r_n     = r;
    c_n     = c;
    ki_n    = ki;
    kj_n    = kj;
`ifdef CORE_SEQ_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    unique case (state)
      S_IDLE: if (bus.start) begin
        state_n = S_W_L0;
        t_n     = '0;
        kij_n   = '0;
      end
      S_W_L0: if (t == COL8) begin
        state_n = S_LOAD;
        t_n     = '0;
      end else t_n = t + 8'd1;
      S_LOAD: if (t == T_LOAD_E) begin
        state_n = S_GAP;
        t_n     = '0;
      end else t_n = t + 8'd1;
      S_GAP: if (t == T_GAP_E) begin
        state_n = S_A_L0;
        t_n     = '0;
      end else t_n = t + 8'd1;
      S_A_L0: if (t == NIJ8) begin
        state_n = S_EXEC;
        t_n     = '0;
      end else t_n = t + 8'd1;
      S_EXEC: if (t == T_EXEC_E) begin
        state_n = S_DRAIN_WAIT;
        t_n     = '0;
      end else t_n = t + 8'd1;
      S_DRAIN_WAIT: begin
        if (bus.ofifo_valid) begin
          state_n = S_DRAIN;
          t_n     = '0;
        end
`ifdef CORE_SEQ_TIMEOUT_EN
        else if (t == T_TMO_E) begin
          state_n = S_IDLE;
          t_n     = '0;
          tmo_hit = 1'b1;
        end
`endif
        else t_n = t + 8'd1;
      end
      S_DRAIN: if (t == T_DRAIN_E) begin
        t_n = '0;
        if (kij == KIJ_E) begin
          state_n = S_ACC_CLR;
          o_n     = '0;
          r_n     = '0;
          c_n     = '0;
        end else begin
          state_n = S_W_L0;
          kij_n   = kij + 4'd1;
        end
      end else t_n = t + 8'd1;
      S_ACC_CLR: begin
        state_n = S_ACC_RD;
        t_n     = '0;
        ki_n    = '0;
        kj_n    = '0;
      end
      S_ACC_RD: if (t == KIJ8) begin
        state_n = S_ACC_END;
        t_n     = '0;
      end else begin
        // ki/kj track k = t so the psum address needs no divider
        t_n = t + 8'd1;
        if (kj == KJ_E) begin
          kj_n = '0;
          ki_n = ki + 2'd1;
        end else kj_n = kj + 2'd1;
      end
      S_ACC_END: state_n = S_OUT;
      S_OUT: if (o == O_E) begin
        state_n = S_DONE;
      end else begin
        state_n = S_ACC_CLR;
        o_n     = o + 4'd1;
        if (c == C_E) begin
          c_n = '0;
          r_n = r + 2'd1;
        end else c_n = c + 2'd1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign acc_addr = 11'(t_n) * NIJ11 + (11'(r_n) + 11'(ki_n)) * IN_W11
                  + 11'(c_n) + 11'(kj_n);

  // Outputs are decoded from the next state so they land registered with it.
  always_comb begin
    inst_n       = INST_IDLE;
    core_reset_n = 1'b0;
    out_valid_n  = 1'b0;
    out_idx_n    = '0;
    done_n       = 1'b0;
    busy_n       = (state_n != S_IDLE) && (state_n != S_DONE);
    case (state_n)
      S_W_L0: begin
        if (t_n < COL8) begin
          inst_n[B_CEN_X] = 1'b0;
          inst_n[17:7]    = w_base + 11'(kij_n) * COL11 + 11'(t_n);
        end
        if (t_n != 8'd0) inst_n[B_L0_WR] = 1'b1;
      end
      S_LOAD: begin
        inst_n[B_L0_RD] = 1'b1;
        inst_n[B_LOAD]  = 1'b1;
      end
      S_A_L0: begin
        if (t_n < NIJ8) begin
          inst_n[B_CEN_X] = 1'b0;
          inst_n[17:7]    = 11'(t_n);
        end
        if (t_n != 8'd0) inst_n[B_L0_WR] = 1'b1;
      end
      S_EXEC: if (t_n < NIJ8) begin
        inst_n[B_EXEC]  = 1'b1;
        inst_n[B_L0_RD] = 1'b1;
      end
      S_DRAIN_WAIT: inst_n[B_OFIFO_RD] = 1'b1;
      S_DRAIN: begin
        inst_n[B_OFIFO_RD] = 1'b1;
        inst_n[B_CEN_P]    = 1'b0;
        inst_n[B_WEN_P]    = 1'b0;
        inst_n[30:20]      = 11'(kij_n) * NIJ11 + 11'(t_n);
      end
      S_ACC_CLR: core_reset_n = 1'b1;
      S_ACC_RD: begin
        if (t_n < KIJ8) begin
          inst_n[B_CEN_P] = 1'b0;
          inst_n[30:20]   = acc_addr;
        end
        if (t_n != 8'd0) inst_n[B_ACC] = 1'b1;
      end
      S_OUT: begin
        out_valid_n = 1'b1;
        out_idx_n   = o_n;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

`ifdef CORE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.inst       = inst_q;
  assign bus.core_reset = core_reset_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
